// File: rtl/pulse_rx_pkg.sv
// Shared types and constants for the pulse receiver.
package pulse_rx_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int PCNT_W    = 16;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    MEASURE  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/pulse_rx_sync.sv
// Two-flop synchronizer for the asynchronous pulse line; clears to 0 on reset.
module pulse_rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: shift the raw line through two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pulse_receiver.sv
// Pulse width receiver: measures high time of signal_in in clock cycles,
// rejects glitches shorter than MIN_WIDTH, and hands results out through a
// valid/ready register with a sticky overrun flag.
// Optional: define PULSE_RX_SYNC_EN to put a 2-flop synchronizer on signal_in.
module pulse_receiver
  import pulse_rx_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int MIN_WIDTH = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              signal_in,
  output logic [CNT_W-1:0]  width_out,
  output logic              valid,
  input  logic              ready,
  output logic              saturated,
  output logic              overrun,
  output logic [PCNT_W-1:0] pulse_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic s;        // line as seen by the FSM
  logic line_ok;  // s reflects the real line (not synchronizer reset value)

`ifdef PULSE_RX_SYNC_EN
  logic [1:0] warm_q, warm_d;

  pulse_rx_sync u_sync (
    .clock (clock),
    .reset (reset),
    .d     (signal_in),
    .q     (s)
  );

  // After reset the synchronizer output reads 0 for two edges regardless of
  // the line; ignore it until real samples arrive so a line held high across
  // reset is not mistaken for a low.
  always_comb warm_d = {warm_q[0], 1'b1};

  // Warm-up shift register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) warm_q <= 2'b00;
    else       warm_q <= warm_d;
  end

  assign line_ok = warm_q[1];
`else
  assign s       = signal_in;
  assign line_ok = 1'b1;
`endif

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              sat_q, sat_d;       // current pulse reached CNT_MAX
  logic [CNT_W-1:0]  width_q, width_d;
  logic              valid_q, valid_d;
  logic              satout_q, satout_d;
  logic              overrun_q, overrun_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;

  // Next-state: FSM transitions, width counting and result hand-off.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    sat_d     = sat_q;
    width_d   = width_q;
    valid_d   = valid_q;
    satout_d  = satout_q;
    overrun_d = overrun_q;
    pcnt_d    = pcnt_q;

    // Consumer takes the held result; an acceptance below may refill it.
    if (valid_q && ready) valid_d = 1'b0;

    unique case (state_q)
      WAIT_LOW: begin
        if (line_ok && !s) state_d = IDLE;
      end
      IDLE: begin
        if (s) begin
          state_d = MEASURE;
          count_d = CNT_ONE;
          sat_d   = (CNT_ONE == CNT_MAX);
        end
      end
      MEASURE: begin
        if (s) begin
          if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_ONE;
            if (count_q + CNT_ONE == CNT_MAX) sat_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
          if (32'(count_q) >= MIN_WIDTH) begin
            pcnt_d = pcnt_q + PCNT_W'(1);
            if (!valid_q || ready) begin
              width_d  = count_q;
              satout_d = sat_q;
              valid_d  = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= WAIT_LOW;
      count_q   <= '0;
      sat_q     <= 1'b0;
      width_q   <= '0;
      valid_q   <= 1'b0;
      satout_q  <= 1'b0;
      overrun_q <= 1'b0;
      pcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      sat_q     <= sat_d;
      width_q   <= width_d;
      valid_q   <= valid_d;
      satout_q  <= satout_d;
      overrun_q <= overrun_d;
      pcnt_q    <= pcnt_d;
    end
  end

  assign width_out   = width_q;
  assign valid       = valid_q;
  assign saturated   = satout_q;
  assign overrun     = overrun_q;
  assign pulse_count = pcnt_q;

endmodule

// File: doc/pulse_receiver.md
PULSE_RECEIVER -- requirements
Module: pulse_receiver

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width-counter and width_out bit width.
REQ-002 SHALL have parameter MIN_WIDTH, default 1: shortest accepted pulse, in clock cycles; shorter pulses are rejected as glitches.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port signal_in, input, 1: asynchronous pulse line driven by the pulse source.
REQ-006 SHALL have port width_out, output, CNT_W: measured high time of the last accepted pulse, in cycles.
REQ-007 SHALL have port valid, output, 1: width_out holds an unconsumed result.
REQ-008 SHALL have port ready, input, 1: consumer accepts the result.
REQ-009 SHALL have port saturated, output, 1: the result in width_out hit the 2^CNT_W-1 limit.
REQ-010 SHALL have port overrun, output, 1: sticky; set when a result was dropped.
REQ-011 SHALL have port pulse_count, output, 16: number of accepted pulses, wraps modulo 2^16.

Function
REQ-012 SHALL sample the synchronized line s on every rising clock edge.
REQ-013 SHALL implement FSM states WAIT_LOW, IDLE and MEASURE.
REQ-014 WAIT_LOW SHALL go to IDLE on the first s==0 sample, so a line already high at reset release is never measured.
REQ-015 IDLE SHALL go to MEASURE on an s==1 sample, loading count=1.
REQ-016 MEASURE SHALL increment count on each s==1 sample, saturating at 2^CNT_W-1 without wrap; any saturation in the current pulse sets a per-pulse sat flag.
REQ-017 MEASURE SHALL go to IDLE on the first s==0 sample; on that edge the pulse is accepted if count>=MIN_WIDTH, otherwise it is discarded with no output change.
REQ-018 On acceptance with valid==0, or with valid==1 and ready==1 in the same cycle, width_out<=count, saturated<=sat, valid<=1 and pulse_count increments, all on the same edge.
REQ-019 On acceptance with valid==1 and ready==0, the new result SHALL be dropped, width_out, saturated and valid SHALL be unchanged, overrun<=1, and pulse_count still increments.
REQ-020 When valid==1, ready==1 and there is no acceptance, valid<=0 on that edge; width_out SHALL hold its value.
REQ-021 A pulse still high when the 16-bit pulse_count wraps SHALL count normally; only pulse_count wraps.
REQ-022 Latency from the edge at which s is first sampled low to valid high SHALL be 1 cycle.

Reset
REQ-023 While reset==1, regardless of clock: state=WAIT_LOW, count=0, width_out=0, valid=0, saturated=0, overrun=0, pulse_count=0, and synchronizer flops=0.
REQ-024 Reset asserted mid-pulse SHALL abort the measurement, and no result for that pulse SHALL ever be produced.

Configuration
REQ-025 Macro PULSE_RX_SYNC_EN defined: signal_in passes through a 2-flop synchronizer, so s lags signal_in by 2 cycles and the signal_in fall to valid latency is 3 cycles.
REQ-026 Macro PULSE_RX_SYNC_EN undefined: s is signal_in directly, and the signal_in fall to valid latency is 1 cycle.
REQ-027 Measured widths SHALL be identical with and without PULSE_RX_SYNC_EN.

Structure
REQ-028 Package pulse_rx_pkg SHALL hold the FSM state enum (WAIT_LOW, IDLE, MEASURE), the CNT_W default and the pulse_count width constant 16.
REQ-029 Sub-module pulse_rx_sync SHALL contain the 2-flop synchronizer, with asynchronous reset to 0, instantiated only under PULSE_RX_SYNC_EN.

Verification
REQ-030 Setup: clock half-period 12, source updates on the clock falling edge, reset for 30 time units, ready=1. Stimulus: signal_in high for 48 time units (2 cycles). Required: width_out=2, valid for 1 cycle, saturated=0, pulse_count=1.
REQ-031 Setup: default parameters. Stimulus: signal_in high for 300 cycles. Required: width_out=255, saturated=1, pulse_count=1.
REQ-032 Setup: ready=0. Stimulus: pulses of 3 and 5 cycles separated by 2 low cycles. Required: width_out=3 held, valid=1, overrun=1, pulse_count=2.
REQ-033 Setup: none. Stimulus: reset pulsed at cycle 4 of a 10-cycle pulse. Required: all outputs 0, and no valid until a later full low-to-high-to-low pulse.
REQ-034 Setup: valid=1 and ready=1 on the same edge where a 4-cycle pulse is accepted. Required: width_out=4, valid stays 1, overrun=0.
REQ-035 Setup: MIN_WIDTH=2. Stimulus: a 1-cycle pulse. Required: no valid, pulse_count unchanged. Stimulus: then a 2-cycle pulse. Required: width_out=2.
